// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 demultiplexer with one single-entry valid/ready buffer per lane.
// Define AUTO_SEL_EN to steer words by an internal round-robin pointer instead of in_sel.
module demux_1to8_reg #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_sel,
  input  logic [N-1:0]   in_data,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ready,
  output logic [8*N-1:0] out_data
);

  logic [7:0]     valid_q, valid_d;
  logic [8*N-1:0] data_q, data_d;
  logic [2:0]     lane;
  logic           accept;

`ifdef AUTO_SEL_EN
  logic [2:0] ptr_q, ptr_d;
  logic       unused_sel;

  assign unused_sel = ^in_sel;
  assign lane       = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ptr_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign lane = in_sel;
`endif

  // A full lane can still accept when its consumer drains it in the same cycle.
  assign in_ready = !valid_q[lane] || out_ready[lane];
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    if (accept) begin
      valid_d[lane]          = 1'b1;
      data_d[lane*N +: N]    = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_demux_1to8_reg.sv
// Scoreboard bench for demux_1to8_reg: accepted words are queued per lane and
// checked by an independent monitor when the lane drains.
module tb_demux_1to8_reg;

  localparam int unsigned N = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2:0]     in_sel = '0;
  logic [N-1:0]   in_data = '0;
  logic [7:0]     out_valid;
  logic [7:0]     out_ready = '0;
  logic [8*N-1:0] out_data;

  demux_1to8_reg #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef logic [N-1:0] word_q_t[$];
  word_q_t    lane_q [8];
  logic [7:0] m_valid = '0;
  logic [2:0] m_ptr   = '0;
  int         checks  = 0;
  int         passes  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [N-1:0] lane_word(input int unsigned i);
    logic [8*N-1:0] all;
    all = out_data;
    return all[i*N +: N];
  endfunction

  // Monitor: every drain handshake must deliver the oldest word queued for that lane.
  always @(negedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
          if (lane_q[i].size() == 0) chk($sformatf("drain_empty_lane%0d", i), 64'd1, 64'd0);
          else chk($sformatf("drain_lane%0d", i), 64'(lane_word(i)), 64'(lane_q[i].pop_front()));
        end
      end
    end
  end

  // One clock of stimulus; tracks lane occupancy and pushes accepted words.
  task automatic step(input logic v, input logic [2:0] s, input logic [N-1:0] dat,
                      input logic [7:0] ordy, input logic r);
    logic [2:0] d;
    logic       exp_rdy;
    rst = r; in_valid = v; in_sel = s; in_data = dat; out_ready = ordy;
    @(negedge clk);
`ifdef AUTO_SEL_EN
    d = m_ptr;
`else
    d = s;
`endif
    exp_rdy = !m_valid[d] || ordy[d];
    if (!r) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    end
    if (r) begin
      m_valid = '0;
      m_ptr   = '0;
      for (int unsigned i = 0; i < 8; i++) lane_q[i].delete();
    end else begin
      m_valid = m_valid & ~ordy;
      if (v && exp_rdy) begin
        m_valid[d] = 1'b1;
        lane_q[d].push_back(dat);
        m_ptr = m_ptr + 3'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1'b0, 3'd0, '0, 8'h00, 1'b1);
    step(1'b0, 3'd0, '0, 8'h00, 1'b1);
    chk("reset_out_valid", 64'(out_valid), 64'h00);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    for (int unsigned i = 0; i < 8; i++)
      chk($sformatf("reset_data%0d", i), 64'(lane_word(i)), 64'h0);
    step(1'b0, 3'd0, '0, 8'h00, 1'b0);

`ifdef AUTO_SEL_EN
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b1, 3'd7, 32'h10 + i, 8'hFF, 1'b0);
      chk($sformatf("auto_onehot%0d", i), 64'(out_valid), 64'(8'h01 << (i % 8)));
      chk($sformatf("auto_data%0d", i), 64'(lane_word(i % 8)), 64'(32'h10 + i));
      if (i == 3) begin
        step(1'b0, 3'd0, '0, 8'hFF, 1'b0);
        chk("auto_idle", 64'(out_valid), 64'h00);
      end
    end
    chk("auto_after10", 64'(out_valid), 64'h02);
    step(1'b1, 3'd0, 32'h1A, 8'hFF, 1'b0);
    chk("auto_ptr_is_2", 64'(out_valid), 64'h04);
    chk("auto_ptr_data", 64'(lane_word(2)), 64'h1A);
`else
    for (int unsigned i = 0; i < 8; i++) step(1'b1, 3'(i), 32'hA0 + i, 8'h00, 1'b0);
    chk("fill_valid", 64'(out_valid), 64'hFF);
    for (int unsigned i = 0; i < 8; i++)
      chk($sformatf("fill_data%0d", i), 64'(lane_word(i)), 64'(32'hA0 + i));
    chk("full_lane3_blocked", 64'(in_ready), 64'd0);
    step(1'b1, 3'd3, 32'hB3, 8'h00, 1'b0);
    step(1'b1, 3'd3, 32'hB3, 8'h08, 1'b0);
    chk("release_valid", 64'(out_valid), 64'hFF);
    chk("release_lane3", 64'(lane_word(3)), 64'hB3);
    chk("release_lane2", 64'(lane_word(2)), 64'hA2);
    chk("release_lane4", 64'(lane_word(4)), 64'hA4);
    step(1'b1, 3'd5, 32'hC5, 8'hFF, 1'b0);
    chk("multidrain_valid", 64'(out_valid), 64'h20);
    chk("multidrain_lane5", 64'(lane_word(5)), 64'hC5);
    chk("multidrain_lane0_held", 64'(lane_word(0)), 64'hA0);
    step(1'b0, 3'd0, '0, 8'h20, 1'b0);
    step(1'b0, 3'd0, '0, 8'h01, 1'b0);
    step(1'b1, 3'd0, 32'hD0, 8'h00, 1'b0);
    step(1'b1, 3'd2, 32'hD2, 8'h00, 1'b0);
    chk("pre_reset_valid", 64'(out_valid), 64'h05);
    step(1'b1, 3'd4, 32'hEE, 8'h00, 1'b1);
    chk("midreset_valid", 64'(out_valid), 64'h00);
    chk("midreset_lane4", 64'(lane_word(4)), 64'h0);
    chk("midreset_lane0", 64'(lane_word(0)), 64'h0);
    step(1'b1, 3'd6, 32'hF6, 8'h00, 1'b0);
    chk("post_reset_lane6", 64'(lane_word(6)), 64'hF6);
`endif

    step(1'b0, 3'd0, '0, 8'hFF, 1'b0);
    step(1'b0, 3'd0, '0, 8'h00, 1'b0);
    chk("final_empty", 64'(out_valid), 64'h00);
    for (int unsigned i = 0; i < 8; i++)
      chk($sformatf("queue_left%0d", i), 64'(lane_q[i].size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
